prog_loader: RTL and testbench



---
 rtl/prog_loader_pkg.sv | 16 +
 rtl/prog_loader_if.sv | 23 ++
 rtl/prog_loader_byte_packer.sv | 48 ++++
 rtl/prog_loader.sv | 135 +++++++++++++
 tb/tb_prog_loader.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-image loader: FSM state encoding and word geometry.
// No logic, no latency.
// No backpressure.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_DATA  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/prog_loader_if.sv
// Host byte link plus loader-owned memory write port, bundled for the loader boundary.
// No logic, no latency.
// rx_valid/rx_ready handshake on the byte side; the memory side has no backpressure.
interface prog_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;

  // Host / memory-observer side
  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_addr, mem_wdata, mem_write
  );

  // Loader side
  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_addr, mem_wdata, mem_write
  );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// MSB-first byte-to-word packer; stores 3 bytes, the 4th completes the word combinationally.
// full and word_nxt are valid in the same cycle as the completing push.
// No backpressure: every push is taken; clear wins over push.
module prog_loader_byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_nxt,
  output logic [1:0]  idx,
  output logic        full
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  idx_q, idx_d;

  // Shift the new byte in at the LSB end and advance the byte index
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (push) begin
      shift_d = {shift_q[15:0], byte_in};
      idx_d   = idx_q + 2'd1;
    end
  end

  // Packer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  assign word_nxt = {shift_q, byte_in};
  assign idx      = idx_q;
  assign full     = push && !clear && (idx_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/prog_loader.sv
// Boot loader: length header + big-endian words from a byte link, written to memory; holds core reset.
// Last byte of a word at t -> mem_write at t+1; last word -> done at t+2, cpu_reset low at t+3.
// rx_ready only in HDR/DATA; bytes wait while a word is being written or after DONE/ERR.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 64,
  parameter int          TIMEOUT   = 1000
) (
  input  logic         clk,
  input  logic         reset,
  prog_loader_if.slave bus,
  input  logic         restart,
  output logic         cpu_reset,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam int IW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   remaining_q, remaining_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          cpu_reset_q, cpu_reset_d;

  logic          rx_ready;
  logic          accept;
  logic          in_frame;
  logic          pk_clear;
  logic          pk_full;
  logic [1:0]    pk_idx;
  logic [31:0]   pk_word;

  assign rx_ready = !reset && (state_q == ST_HDR || state_q == ST_DATA);
  assign accept   = bus.rx_valid && rx_ready;
  assign pk_clear = (state_q == ST_DONE) || (state_q == ST_ERR);
  // A frame is "open" once any header byte has arrived; an empty HDR waits forever
  assign in_frame = (state_q == ST_HDR && pk_idx != 2'd0) || (state_q == ST_DATA);

  prog_loader_byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (pk_clear),
    .push     (accept),
    .byte_in  (bus.rx_data),
    .word_nxt (pk_word),
    .idx      (pk_idx),
    .full     (pk_full)
  );

  // Next-state, counters and idle watchdog
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    remaining_d = remaining_q;
    idle_d      = '0;

    if (in_frame && !accept) begin
      if (idle_q == IW'(TIMEOUT - 1)) begin
        state_d = ST_ERR;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end

    case (state_q)
      ST_HDR: begin
        if (pk_full) begin
          if (pk_word == 32'd0 || pk_word > 32'(MAX_WORDS)) begin
            state_d = ST_ERR;
          end else begin
            remaining_d = pk_word;
            state_d     = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (pk_full) begin
          wdata_d = pk_word;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d      = addr_q + 32'(WORD_BYTES);
        remaining_d = remaining_q - 32'd1;
        state_d     = (remaining_q == 32'd1) ? ST_DONE : ST_DATA;
      end
      ST_DONE, ST_ERR: begin
        if (restart) begin
          state_d     = ST_HDR;
          addr_d      = BASE_ADDR;
          remaining_d = '0;
        end
      end
      default: state_d = ST_ERR;
    endcase

    // Release the core only after a full cycle in DONE; re-assert as soon as DONE is left
    cpu_reset_d = !(state_q == ST_DONE && state_d == ST_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HDR;
      addr_q      <= BASE_ADDR;
      wdata_q     <= '0;
      remaining_q <= '0;
      idle_q      <= '0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      remaining_q <= remaining_d;
      idle_q      <= idle_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  assign bus.rx_ready  = rx_ready;
  assign bus.mem_write = (state_q == ST_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign busy          = in_frame || (state_q == ST_WRITE);
  assign done          = (state_q == ST_DONE);
  assign error         = (state_q == ST_ERR);

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam int          MAX_WORDS = 64;
  localparam int          TIMEOUT   = 1000;

  logic clk;
  logic rst;
  logic restart;
  logic cpu_reset, busy, done, error;

  int n_checks = 0;
  int n_err    = 0;

  prog_loader_if bus();

  prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (rst),
    .bus       (bus),
    .restart   (restart),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int          m_hdr_got, m_words_left, m_byte_pos, m_idle;
  logic [31:0] m_hdr, m_word, m_next_addr, m_wr_addr, m_wr_data;
  bit          m_in_data, m_wr, m_fin, m_bad, m_cpu_rst, m_take, m_fin_old;
  logic        m_ready;

  assign m_ready = !rst && !m_fin && !m_bad && !m_wr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hdr_got = 0; m_words_left = 0; m_byte_pos = 0; m_idle = 0;
      m_hdr = '0; m_word = '0; m_next_addr = BASE;
      m_in_data = 0; m_wr = 0; m_fin = 0; m_bad = 0; m_cpu_rst = 1;
    end else begin
      m_fin_old = m_fin;
      m_take    = bus.rx_valid && !m_fin && !m_bad && !m_wr;
      if (m_fin || m_bad) begin
        if (restart) begin
          m_fin = 0; m_bad = 0; m_hdr_got = 0; m_in_data = 0;
          m_byte_pos = 0; m_idle = 0; m_next_addr = BASE;
        end
      end else if (m_wr) begin
        m_wr = 0;
        m_next_addr = m_next_addr + 32'd4;
        m_words_left--;
        if (m_words_left == 0) begin
          m_fin = 1;
          m_in_data = 0;
        end
      end else if (m_take) begin
        m_idle = 0;
        if (!m_in_data) begin
          m_hdr = {m_hdr[23:0], bus.rx_data};
          m_hdr_got++;
          if (m_hdr_got == 4) begin
            m_hdr_got = 0;
            if (m_hdr == 0 || m_hdr > 32'(MAX_WORDS)) m_bad = 1;
            else begin
              m_words_left = int'(m_hdr);
              m_in_data = 1;
            end
          end
        end else begin
          m_word = {m_word[23:0], bus.rx_data};
          m_byte_pos++;
          if (m_byte_pos == 4) begin
            m_byte_pos = 0;
            m_wr = 1;
            m_wr_addr = m_next_addr;
            m_wr_data = m_word;
          end
        end
      end else if (m_hdr_got > 0 || m_in_data) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_bad = 1; m_idle = 0; m_hdr_got = 0; m_in_data = 0; m_byte_pos = 0;
        end
      end
      m_cpu_rst = !(m_fin_old && m_fin);
    end
  end

  // ---------------- per-cycle compare + write log ----------------
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  always @(negedge clk) begin
    chk("rx_ready", 32'(bus.rx_ready), 32'(m_ready));
    chk("mem_write", 32'(bus.mem_write), 32'(m_wr));
    chk("done", 32'(done), 32'(m_fin));
    chk("error", 32'(error), 32'(m_bad));
    chk("cpu_reset", 32'(cpu_reset), 32'(m_cpu_rst));
    chk("busy", 32'(busy), 32'(!m_fin && !m_bad && (m_hdr_got > 0 || m_in_data)));
    if (bus.mem_write && m_wr) begin
      chk("mem_addr", bus.mem_addr, m_wr_addr);
      chk("mem_wdata", bus.mem_wdata, m_wr_data);
    end
    if (bus.mem_write === 1'b1) begin
      log_addr.push_back(bus.mem_addr);
      log_data.push_back(bus.mem_wdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    int n;
    ok = 0;
    n  = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = bus.rx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("byte_accept_timeout", 32'(ok), 32'd1);
    if (gap) begin
      bus.rx_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(t[31:24], gap);
      t = t << 8;
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    chk("restart_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("restart_mem_addr", bus.mem_addr, BASE);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int nw;
    rst = 1'b1;
    restart = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, BASE);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Two-word image, rx_valid held high
    send_word(32'h0000_0002, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    chk("t1_w0_write", 32'(bus.mem_write), 32'd1);
    chk("t1_w0_addr", bus.mem_addr, 32'h0);
    chk("t1_w0_data", bus.mem_wdata, 32'hDEAD_BEEF);
    send_word(32'h0123_4567, 1'b0);
    bus.rx_valid = 1'b0;
    chk("t1_w1_write", 32'(bus.mem_write), 32'd1);
    chk("t1_w1_addr", bus.mem_addr, 32'h4);
    chk("t1_w1_data", bus.mem_wdata, 32'h0123_4567);
    chk("t1_done_early", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_done_t2", 32'(done), 32'd1);
    chk("t1_cpu_reset_t2", 32'(cpu_reset), 32'd1);
    @(posedge clk);
    #1;
    chk("t1_cpu_reset_t3", 32'(cpu_reset), 32'd0);
    chk("t1_write_count", 32'(log_addr.size()), 32'd2);
    do_restart();

    // Zero-length header
    nw = log_addr.size();
    send_word(32'h0000_0000, 1'b0);
    bus.rx_valid = 1'b0;
    chk("t2_error", 32'(error), 32'd1);
    chk("t2_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t2_rx_ready", 32'(bus.rx_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t2_no_write", 32'(log_addr.size()), 32'(nw));
    do_restart();

    // Oversized header (65 > 64)
    send_word(32'h0000_0041, 1'b0);
    bus.rx_valid = 1'b0;
    chk("t3_error", 32'(error), 32'd1);
    do_restart();

    // Timeout inside a word
    nw = log_addr.size();
    send_word(32'h0000_0001, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    bus.rx_valid = 1'b0;
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    chk("t4_error_before", 32'(error), 32'd0);
    @(posedge clk);
    #1;
    chk("t4_error_at", 32'(error), 32'd1);
    chk("t4_no_write", 32'(log_addr.size()), 32'(nw));
    do_restart();

    // rx_valid toggling, one-word image
    nw = log_addr.size();
    send_word(32'h0000_0001, 1'b1);
    send_word(32'h1122_3344, 1'b1);
    wait_done("t5_done");
    chk("t5_write_count", 32'(log_addr.size()), 32'(nw + 1));
    if (log_addr.size() == nw + 1) begin
      chk("t5_addr", log_addr[nw], BASE);
      chk("t5_data", log_data[nw], 32'h1122_3344);
    end
    do_restart();

    // Asynchronous reset mid-word, then reload
    nw = log_addr.size();
    send_word(32'h0000_0001, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    bus.rx_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("t6_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("t6_mem_write", 32'(bus.mem_write), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_mem_addr", bus.mem_addr, BASE);
    chk("t6_mem_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_word(32'h0000_0001, 1'b0);
    send_word(32'hCAFE_F00D, 1'b0);
    bus.rx_valid = 1'b0;
    wait_done("t6_done");
    chk("t6_write_count", 32'(log_addr.size()), 32'(nw + 1));
    if (log_addr.size() == nw + 1) begin
      chk("t6_addr", log_addr[nw], BASE);
      chk("t6_data", log_data[nw], 32'hCAFE_F00D);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("t6_cpu_released", 32'(cpu_reset), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
